// File: rtl/tb_irq_timer_bank.sv
// Memory-mapped bank of N_IRQ compare-match interrupt channels, each one-shot or periodic.
// Pending bits drive irq_o and are cleared by the core's ack or by a W1C write to PENDING.
module tb_irq_timer_bank #(
   parameter int unsigned N_IRQ     = 32,
   parameter int unsigned CNT_WIDTH = 32,
   parameter int unsigned ID_WIDTH  = 5
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  logic                req_i,
   input  logic [11:0]         addr_i,
   input  logic                we_i,
   input  logic [3:0]          be_i,
   input  logic [31:0]         wdata_i,
   output logic                gnt_o,
   output logic                rvalid_o,
   output logic [31:0]         rdata_o,
   input  logic                irq_ack_i,
   input  logic [ID_WIDTH-1:0] irq_id_i,
   output logic [N_IRQ-1:0]    irq_o
);

   localparam int unsigned IdxW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
   localparam logic [CNT_WIDTH-1:0] CntOne = CNT_WIDTH'(1);

   // Per-channel state
   logic [N_IRQ-1:0]     r_en, r_per, r_pend;
   logic [CNT_WIDTH-1:0] r_cmp [N_IRQ];
   logic [CNT_WIDTH-1:0] r_cnt [N_IRQ];
   logic                 r_rvalid;
   logic [31:0]          r_rdata;

   // Next-state
   logic [N_IRQ-1:0]     w_en_d, w_per_d, w_pend_d, w_match;
   logic [CNT_WIDTH-1:0] w_cmp_d [N_IRQ];
   logic [CNT_WIDTH-1:0] w_cnt_d [N_IRQ];

   // Address decode
   logic [7:0]      w_blk;
   logic [7:0]      w_ch;
   logic [IdxW-1:0] w_idx;
   logic [1:0]      w_reg;
   logic            w_is_ch;
   logic            w_wr;
   logic            w_pend_wr;
   logic [31:0]     w_bmask;
   logic [31:0]     w_wdata_m;
   logic [31:0]     w_rdata;
   logic [N_IRQ-1:0] w_wr_ctrl, w_wr_cmp, w_wr_cnt, w_clr;
   logic            w_unused;

   // Channel blocks start at 0x010; block n maps to channel n-1
   assign w_blk     = addr_i[11:4];
   assign w_ch      = w_blk - 8'd1;
   assign w_idx     = w_ch[IdxW-1:0];
   assign w_reg     = addr_i[3:2];
   assign w_is_ch   = (w_blk != 8'd0) && (32'(w_blk) <= N_IRQ);
   assign w_wr      = req_i & we_i;
   assign w_pend_wr = w_wr && (addr_i[11:2] == 10'd0);
   assign w_bmask   = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
   assign w_wdata_m = wdata_i & w_bmask;

   assign gnt_o    = req_i;
   assign rvalid_o = r_rvalid;
   assign rdata_o  = r_rdata;
   assign irq_o    = r_pend;

   assign w_unused = ^{addr_i[1:0], wdata_i, w_bmask, w_wdata_m, w_ch};

   // Decode per-channel register writes and pending clears
   always_comb begin
      w_wr_ctrl = '0;
      w_wr_cmp  = '0;
      w_wr_cnt  = '0;
      w_clr     = '0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         if (w_wr && w_is_ch && (32'(w_ch) == i)) begin
            w_wr_ctrl[i] = (w_reg == 2'd0);
            w_wr_cmp[i]  = (w_reg == 2'd1);
            w_wr_cnt[i]  = (w_reg == 2'd2);
         end
         w_clr[i] = (irq_ack_i && (32'(irq_id_i) == i)) ||
                    (w_pend_wr && wdata_i[i] && be_i[i / 8]);
      end
   end

   // Channel next-state: bus write beats count/match, match-set beats clears
   always_comb begin
      w_en_d   = r_en;
      w_per_d  = r_per;
      w_pend_d = r_pend;
      w_match  = '0;
      for (int unsigned i = 0; i < N_IRQ; i++) begin
         w_cmp_d[i] = r_cmp[i];
         w_cnt_d[i] = r_cnt[i];
         w_match[i] = r_en[i] && !(w_wr_ctrl[i] || w_wr_cmp[i] || w_wr_cnt[i]) &&
                      (r_cnt[i] == r_cmp[i]);
         if (w_wr_ctrl[i]) begin
            if (be_i[0]) begin
               w_en_d[i]  = wdata_i[0];
               w_per_d[i] = wdata_i[1];
            end
         end else if (w_wr_cmp[i]) begin
            w_cmp_d[i] = (r_cmp[i] & ~w_bmask[CNT_WIDTH-1:0]) | w_wdata_m[CNT_WIDTH-1:0];
         end else if (w_wr_cnt[i]) begin
            w_cnt_d[i] = (r_cnt[i] & ~w_bmask[CNT_WIDTH-1:0]) | w_wdata_m[CNT_WIDTH-1:0];
         end else if (r_en[i]) begin
            if (w_match[i]) begin
               if (r_per[i]) begin
                  w_cnt_d[i] = '0;
               end else begin
                  w_en_d[i] = 1'b0;
               end
            end else begin
               w_cnt_d[i] = r_cnt[i] + CntOne;
            end
         end
         if (w_match[i]) begin
            w_pend_d[i] = 1'b1;
         end else if (w_clr[i]) begin
            w_pend_d[i] = 1'b0;
         end
      end
   end

   // Read mux over current (pre-update) register state
   always_comb begin
      w_rdata = '0;
      if (addr_i[11:2] == 10'd0) begin
         w_rdata[N_IRQ-1:0] = r_pend;
      end else if (addr_i[11:2] == 10'd1) begin
         w_rdata[N_IRQ-1:0] = r_en;
      end else if (w_is_ch) begin
         case (w_reg)
            2'd0:    w_rdata[1:0] = {r_per[w_idx], r_en[w_idx]};
            2'd1:    w_rdata[CNT_WIDTH-1:0] = r_cmp[w_idx];
            2'd2:    w_rdata[CNT_WIDTH-1:0] = r_cnt[w_idx];
            default: w_rdata[0] = r_pend[w_idx];
         endcase
      end
   end

   // State registers and one-cycle bus response
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         r_en     <= '0;
         r_per    <= '0;
         r_pend   <= '0;
         r_rvalid <= 1'b0;
         r_rdata  <= '0;
         for (int unsigned i = 0; i < N_IRQ; i++) begin
            r_cmp[i] <= '0;
            r_cnt[i] <= '0;
         end
      end else begin
         r_en     <= w_en_d;
         r_per    <= w_per_d;
         r_pend   <= w_pend_d;
         r_rvalid <= req_i;
         r_rdata  <= (req_i && !we_i) ? w_rdata : 32'd0;
         for (int unsigned i = 0; i < N_IRQ; i++) begin
            r_cmp[i] <= w_cmp_d[i];
            r_cnt[i] <= w_cnt_d[i];
         end
      end
   end

endmodule

// File: tb/tb_tb_irq_timer_bank.sv
// Directed bench for tb_irq_timer_bank: bus responses checked via an expected-data queue,
// interrupt lines checked inline against hand-derived cycle timing.
module tb_tb_irq_timer_bank;

   localparam int N  = 8;
   localparam int CW = 24;
   localparam int IW = 5;

   localparam logic [11:0] APend = 12'h000;
   localparam logic [11:0] AEna  = 12'h004;

   typedef struct {
      logic [11:0] addr;
      logic [31:0] val;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          req = 1'b0;
   logic [11:0]   addr = '0;
   logic          we = 1'b0;
   logic [3:0]    be = '0;
   logic [31:0]   wdata = '0;
   logic          gnt_o;
   logic          rvalid_o;
   logic [31:0]   rdata_o;
   logic          irq_ack = 1'b0;
   logic [IW-1:0] irq_id = '0;
   logic [N-1:0]  irq_o;

   int   n_tests = 0;
   int   n_fail  = 0;
   exp_t sb[$];
   exp_t e_pop;
   logic exp_rv = 1'b0;

   tb_irq_timer_bank #(
      .N_IRQ    (N),
      .CNT_WIDTH(CW),
      .ID_WIDTH (IW)
   ) dut (
      .clk_i    (clk),
      .rst_ni   (rst_n),
      .req_i    (req),
      .addr_i   (addr),
      .we_i     (we),
      .be_i     (be),
      .wdata_i  (wdata),
      .gnt_o    (gnt_o),
      .rvalid_o (rvalid_o),
      .rdata_o  (rdata_o),
      .irq_ack_i(irq_ack),
      .irq_id_i (irq_id),
      .irq_o    (irq_o)
   );

   always #5 clk = ~clk;

   function automatic logic [11:0] ch_addr(input int ch, input int r);
      return 12'(16 + 16 * ch + 4 * r);
   endfunction

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic push_exp(input logic [11:0] a, input logic [31:0] v);
      exp_t e;
      e.addr = a;
      e.val  = v;
      sb.push_back(e);
   endtask

   task automatic bus_write(input logic [11:0] a, input logic [31:0] d, input logic [3:0] b);
      req = 1'b1; we = 1'b1; addr = a; wdata = d; be = b;
      push_exp(a, 32'h0);
      @(posedge clk);
      #1;
      req = 1'b0; we = 1'b0; be = '0; wdata = '0;
   endtask

   task automatic bus_read(input logic [11:0] a, input logic [31:0] exp);
      req = 1'b1; we = 1'b0; addr = a; be = 4'hF;
      push_exp(a, exp);
      @(posedge clk);
      #1;
      req = 1'b0; be = '0;
   endtask

   task automatic ack(input int id);
      irq_ack = 1'b1;
      irq_id  = IW'(id);
      @(posedge clk);
      #1;
      irq_ack = 1'b0;
   endtask

   // rvalid must follow each granted request by exactly one cycle
   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) exp_rv <= 1'b0;
      else        exp_rv <= req;
   end

   // Response checker: pop the expected read data for every rvalid pulse
   always @(negedge clk) begin
      if (rst_n) begin
         check("rvalid", 32'(rvalid_o), 32'(exp_rv));
         if (rvalid_o) begin
            n_tests++;
            assert (sb.size() > 0) else begin
               n_fail++;
               $error("FAIL sb_underflow: observed 0 queued entries, expected at least 1");
            end
            if (sb.size() > 0) begin
               e_pop = sb.pop_front();
               check($sformatf("rdata@%03h", e_pop.addr), rdata_o, e_pop.val);
            end
         end
      end
   end

   initial begin
      // Reset values and grant passthrough during reset
      #1;
      check("rst_irq", 32'(irq_o), 32'h0);
      check("rst_rvalid", 32'(rvalid_o), 32'h0);
      check("rst_rdata", rdata_o, 32'h0);
      req = 1'b1;
      #1 check("rst_gnt1", 32'(gnt_o), 32'h1);
      req = 1'b0;
      #1 check("rst_gnt0", 32'(gnt_o), 32'h0);
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;
      bus_read(APend, 32'h0);
      bus_read(AEna, 32'h0);
      bus_read(ch_addr(3, 1), 32'h0);

      // One-shot ch3: CMP=5, match 6 cycles after the CTRL write edge
      bus_write(ch_addr(3, 1), 32'd5, 4'hF);
      bus_write(ch_addr(3, 2), 32'd0, 4'hF);
      bus_write(ch_addr(3, 0), 32'h1, 4'h1);
      bus_read(AEna, 32'h08);
      tick(4);
      check("os_pre", 32'(irq_o), 32'h00);
      tick(1);
      check("os_hit", 32'(irq_o), 32'h08);
      bus_read(ch_addr(3, 0), 32'h0);
      bus_read(ch_addr(3, 2), 32'd5);
      bus_read(ch_addr(3, 3), 32'h1);
      bus_read(APend, 32'h08);
      ack(3);
      check("os_ack", 32'(irq_o), 32'h00);

      // Periodic ch0: CMP=2 -> pending every 3 cycles; W1C vs match collision
      bus_write(ch_addr(0, 1), 32'd2, 4'hF);
      bus_write(ch_addr(0, 0), 32'h3, 4'h1);
      tick(2);
      check("per_pre", 32'(irq_o), 32'h00);
      tick(1);
      check("per_hit1", 32'(irq_o), 32'h01);
      tick(2);
      bus_write(APend, 32'h1, 4'h1);
      check("per_w1c_on_match", 32'(irq_o), 32'h01);
      bus_write(APend, 32'h1, 4'h1);
      check("per_w1c_off_match", 32'(irq_o), 32'h00);
      tick(2);
      check("per_hit3", 32'(irq_o), 32'h01);
      bus_write(ch_addr(0, 0), 32'h0, 4'h1);
      bus_write(APend, 32'h1, 4'h1);
      check("per_cleared", 32'(irq_o), 32'h00);
      bus_read(ch_addr(0, 0), 32'h0);

      // Wrap-around ch1: CNT FFFFFE, FFFFFF, 0, 1, match at 1
      bus_write(ch_addr(1, 1), 32'd1, 4'hF);
      bus_write(ch_addr(1, 2), 32'h00FF_FFFE, 4'hF);
      bus_write(ch_addr(1, 0), 32'h1, 4'h1);
      bus_read(ch_addr(1, 2), 32'h00FF_FFFE);
      bus_read(ch_addr(1, 2), 32'h00FF_FFFF);
      bus_read(ch_addr(1, 2), 32'h0000_0000);
      bus_read(ch_addr(1, 2), 32'h0000_0001);
      check("wrap_hit", 32'(irq_o), 32'h02);
      bus_read(ch_addr(1, 2), 32'h0000_0001);

      // Byte enables, width masking, unmapped and read-only locations
      bus_write(ch_addr(2, 1), 32'hAABB_CCDD, 4'b0101);
      bus_read(ch_addr(2, 1), 32'h00BB_00DD);
      bus_write(ch_addr(2, 2), 32'hFFFF_FFFF, 4'hF);
      bus_read(ch_addr(2, 2), 32'h00FF_FFFF);
      bus_write(ch_addr(2, 0), 32'h1, 4'b0010);
      bus_read(ch_addr(2, 0), 32'h0);
      bus_read(12'hFF0, 32'h0);
      bus_write(ch_addr(8, 1), 32'd5, 4'hF);
      bus_read(ch_addr(8, 1), 32'h0);
      bus_write(AEna, 32'hFF, 4'hF);
      bus_read(AEna, 32'h0);

      // Ack colliding with a match on ch7: match wins
      bus_write(ch_addr(7, 1), 32'd3, 4'hF);
      bus_write(ch_addr(7, 0), 32'h1, 4'h1);
      tick(3);
      ack(7);
      check("ack_vs_match", 32'(irq_o), 32'h82);
      ack(8);
      check("ack_id8", 32'(irq_o), 32'h82);
      ack(31);
      check("ack_id31", 32'(irq_o), 32'h82);
      irq_ack = 1'b1;
      irq_id  = IW'(7);
      bus_write(APend, 32'h2, 4'h1);
      irq_ack = 1'b0;
      check("ack_plus_w1c", 32'(irq_o), 32'h00);

      // Async reset mid-transaction with an interrupt pending
      bus_write(ch_addr(0, 2), 32'd0, 4'hF);
      bus_write(ch_addr(0, 0), 32'h3, 4'h1);
      tick(3);
      check("pre_rst_irq", 32'(irq_o), 32'h01);
      req = 1'b1; we = 1'b0; addr = APend; be = 4'hF;
      @(posedge clk);
      #1;
      req = 1'b0; be = '0;
      check("pre_rst_rvalid", 32'(rvalid_o), 32'h1);
      check("pre_rst_rdata", rdata_o, 32'h1);
      rst_n = 1'b0;
      #1;
      check("mid_rst_irq", 32'(irq_o), 32'h0);
      check("mid_rst_rvalid", 32'(rvalid_o), 32'h0);
      check("mid_rst_rdata", rdata_o, 32'h0);
      sb.delete();
      #20 rst_n = 1'b1;
      @(posedge clk);
      #1;
      tick(5);
      check("post_rst_irq", 32'(irq_o), 32'h0);
      bus_read(APend, 32'h0);
      bus_read(AEna, 32'h0);
      bus_read(ch_addr(0, 0), 32'h0);
      bus_read(ch_addr(0, 1), 32'h0);
      bus_read(ch_addr(0, 2), 32'h0);
      bus_read(ch_addr(0, 3), 32'h0);
      bus_read(ch_addr(2, 1), 32'h0);

      tick(2);
      check("sb_drained", 32'(sb.size()), 32'h0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
